// File: rtl/cop_pkg.sv
// rtl/cop_pkg.sv - shared opcodes, sequencer states and word index type for the coprocessor
package cop_pkg;

  localparam logic [31:0] COP_CFG_OP   = 32'h4000_0003;
  localparam logic [31:0] COP_CFG_WORD = 32'h0000_0094;
  localparam logic [31:0] COP_LOAD_OP  = 32'h4000_0000;
  localparam logic [31:0] COP_NOP      = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_CFG_OP,
    S_CFG_DATA,
    S_IDLE,
    S_LOAD,
    S_DATA,
    S_WAIT,
    S_READ,
    S_HOLD
  } cop_state_t;

  typedef logic [1:0] word_idx_t;

endpackage

// File: rtl/cop_host_sequencer.sv
// rtl/cop_host_sequencer.sv - host-side initiator driving the coprocessor instruct/out interface
module cop_host_sequencer
  import cop_pkg::*;
#(
  parameter logic [31:0] CFG_OP      = COP_CFG_OP,
  parameter logic [31:0] CFG_WORD    = COP_CFG_WORD,
  parameter logic [31:0] LOAD_OP     = COP_LOAD_OP,
  parameter int unsigned LOAD_HOLD   = 2,
  parameter int unsigned WAIT_CYCLES = 90,
  parameter bit          ENABLE_CFG  = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] blk_in,
  input  logic         blk_in_valid,
  output logic         blk_in_ready,
  output logic [31:0]  instruct,
  input  logic [31:0]  cop_out,
  output logic [127:0] res_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy
);

  localparam cop_state_t RESET_STATE = ENABLE_CFG ? S_CFG_OP : S_IDLE;

  cop_state_t   state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  word_idx_t    idx_q, idx_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic [31:0]  instr_q, instr_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         accept;
  logic         res_hs;

  assign accept = (state_q == S_IDLE) && blk_in_valid && ready_q;
  assign res_hs = valid_q && res_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RESET_STATE;
      cnt_q   <= 16'd0;
      idx_q   <= 2'd0;
      blk_q   <= 128'd0;
      res_q   <= 128'd0;
      instr_q <= COP_NOP;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= ENABLE_CFG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are registered from the current state, so instruct trails state by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    res_d   = res_q;
    instr_d = COP_NOP;
    unique case (state_q)
      S_CFG_OP: begin
        instr_d = CFG_OP;
        state_d = S_CFG_DATA;
      end
      S_CFG_DATA: begin
        instr_d = CFG_WORD;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          blk_d   = blk_in;
          cnt_d   = 16'(LOAD_HOLD - 1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        instr_d = LOAD_OP;
        if (cnt_q == 16'd0) begin
          idx_d   = 2'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        instr_d = blk_q[{idx_q, 5'd0} +: 32];
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          cnt_d   = 16'(WAIT_CYCLES - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 16'd0) begin
          idx_d   = 2'd0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_READ: begin
        // First sample shifts down to [31:0] after four captures.
        res_d = {cop_out, res_q[127:32]};
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase

    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    valid_d = (state_q == S_HOLD) && !res_hs;
    busy_d  = (state_q != S_IDLE) || (state_d != S_IDLE);
  end

  assign blk_in_ready = ready_q;
  assign instruct     = instr_q;
  assign res_out      = res_q;
  assign res_valid    = valid_q;
  assign busy         = busy_q;

endmodule
